// File: rtl/mem_bus_arbiter_if.sv
// Request, response and external-bus signals of mem_bus_arbiter, grouped for port connection.
// master = arbiter side, slave = requesters plus memory side.
interface mem_bus_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    // Handshakes: a requester raises if_req_i / mem_valid_i and holds it and its
    // operands until the matching *_ready_o one-cycle pulse. bus_req_o is held
    // with stable operands until a one-cycle bus_ack_i, which carries bus_rdata_i.
    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic              if_ready_o;
    logic [DATA_W-1:0] if_rdata_o;

    logic              mem_valid_i;
    logic              mem_rw_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [DATA_W-1:0] mem_wdata_i;
    logic              mem_ready_o;
    logic [DATA_W-1:0] mem_rdata_o;

    logic              bus_req_o;
    logic              bus_we_o;
    logic [ADDR_W-1:0] bus_addr_o;
    logic [DATA_W-1:0] bus_wdata_o;
    logic              bus_ack_i;
    logic [DATA_W-1:0] bus_rdata_i;

    logic              stall_if_o;
    logic              stall_mem_o;
    logic              err_o;

    modport master (
        input  if_req_i, if_addr_i, mem_valid_i, mem_rw_i, mem_addr_i, mem_wdata_i,
               bus_ack_i, bus_rdata_i,
        output if_ready_o, if_rdata_o, mem_ready_o, mem_rdata_o,
               bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o,
               stall_if_o, stall_mem_o, err_o
    );

    modport slave (
        output if_req_i, if_addr_i, mem_valid_i, mem_rw_i, mem_addr_i, mem_wdata_i,
               bus_ack_i, bus_rdata_i,
        input  if_ready_o, if_rdata_o, mem_ready_o, mem_rdata_o,
               bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o,
               stall_if_o, stall_mem_o, err_o
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester (IF, MEM) arbiter for one external memory bus, MEM has fixed priority.
// Optional bus-ack timeout is enabled by defining BUS_TIMEOUT_EN.
module mem_bus_arbiter #(
    parameter int ADDR_W         = 64,
    parameter int DATA_W         = 64,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    mem_bus_arbiter_if.master   bus_if,
    output logic [1:0]          dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUS_MEM = 2'd1,
        BUS_IF  = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic              r_bus_req;
    logic              r_bus_we;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [DATA_W-1:0] r_bus_wdata;
    logic              r_if_ready;
    logic              r_mem_ready;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_mem_rdata;
    logic              r_err;

    logic              w_grant_mem;
    logic              w_grant_if;
    logic              w_waiting;
    logic              w_timeout;
    logic              w_done;

    if (TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("mem_bus_arbiter: TIMEOUT_CYCLES must be at least 1");
    end

    assign w_waiting = (r_state == BUS_MEM) || (r_state == BUS_IF);

`ifdef BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (w_grant_mem || w_grant_if) begin
            r_wait_cnt <= '0;
        end else if (w_waiting && !w_done) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // An ack arriving on the limit cycle wins over the timeout.
    assign w_timeout = w_waiting && !bus_if.bus_ack_i &&
                       (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
    assign w_timeout = 1'b0;
`endif

    assign w_done = w_waiting && (bus_if.bus_ack_i || w_timeout);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_grant_mem  = 1'b0;
        w_grant_if   = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus_if.mem_valid_i) begin
                    w_grant_mem  = 1'b1;
                    w_next_state = BUS_MEM;
                end else if (bus_if.if_req_i) begin
                    w_grant_if   = 1'b1;
                    w_next_state = BUS_IF;
                end
            end
            BUS_MEM, BUS_IF: begin
                if (w_done) begin
                    w_next_state = RESP;
                end
            end
            RESP:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
            r_if_ready  <= 1'b0;
            r_mem_ready <= 1'b0;
            r_if_rdata  <= '0;
            r_mem_rdata <= '0;
            r_err       <= 1'b0;
        end else begin
            r_if_ready  <= 1'b0;
            r_mem_ready <= 1'b0;
            r_err       <= 1'b0;
            if (w_grant_mem) begin
                r_bus_req   <= 1'b1;
                r_bus_we    <= bus_if.mem_rw_i;
                r_bus_addr  <= bus_if.mem_addr_i;
                r_bus_wdata <= bus_if.mem_wdata_i;
            end else if (w_grant_if) begin
                r_bus_req   <= 1'b1;
                r_bus_we    <= 1'b0;
                r_bus_addr  <= bus_if.if_addr_i;
            end else if (w_done) begin
                // Ready pulses during RESP; a timed-out read returns zero.
                r_bus_req <= 1'b0;
                r_err     <= w_timeout;
                if (r_state == BUS_MEM) begin
                    r_mem_ready <= 1'b1;
                    r_mem_rdata <= w_timeout ? '0 : bus_if.bus_rdata_i;
                end else begin
                    r_if_ready  <= 1'b1;
                    r_if_rdata  <= w_timeout ? '0 : bus_if.bus_rdata_i;
                end
            end
        end
    end

    assign bus_if.bus_req_o   = r_bus_req;
    assign bus_if.bus_we_o    = r_bus_we;
    assign bus_if.bus_addr_o  = r_bus_addr;
    assign bus_if.bus_wdata_o = r_bus_wdata;
    assign bus_if.if_ready_o  = r_if_ready;
    assign bus_if.if_rdata_o  = r_if_rdata;
    assign bus_if.mem_ready_o = r_mem_ready;
    assign bus_if.mem_rdata_o = r_mem_rdata;
    assign bus_if.err_o       = r_err;
    assign bus_if.stall_mem_o = bus_if.mem_valid_i & ~r_mem_ready;
    assign bus_if.stall_if_o  = bus_if.if_req_i & ~r_if_ready;
    assign dbg_state_o        = r_state;

endmodule
